traffic_sensor_conditioner: RTL and testbench

- Upstream of traffic_light_controller.
- Conditions the three raw loop-detector inputs: 2-flop synchronizer, then a stable-count debouncer.
- Keeps a per-lane count of waiting vehicles. That count is cleared when the lane's green phase ends.
- Drives the controller's ew_str_sensor, ew_left_sensor and ns_sensor inputs. A lane's sensor stays asserted while its loop is occupied or while unserved arrivals are pending.

---
 rtl/traffic_sensor_conditioner.sv | 136 +++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// traffic_sensor_conditioner
// Synchronizes, debounces and queues three loop-detector inputs for the
// traffic light controller. Optional macro STARVATION_FLAG_EN adds starve flags.
// Revision: 1.0
// ============================================================================
module traffic_sensor_conditioner #(
  parameter int DEB_CYCLES    = 2,
  parameter int CNT_W         = 4,
  parameter int STARVE_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ew_str_raw,
  input  logic             ew_left_raw,
  input  logic             ns_raw,
  input  logic [1:0]       ew_str_light,
  input  logic [1:0]       ew_left_light,
  input  logic [1:0]       ns_light,
  output logic             ew_str_sensor,
  output logic             ew_left_sensor,
  output logic             ns_sensor,
`ifdef STARVATION_FLAG_EN
  output logic             ew_str_starve,
  output logic             ew_left_starve,
  output logic             ns_starve,
`endif
  output logic [CNT_W-1:0] ew_str_count,
  output logic [CNT_W-1:0] ew_left_count,
  output logic [CNT_W-1:0] ns_count
);

  localparam logic [1:0]       c_RED      = 2'b00;
  localparam logic [1:0]       c_GREEN    = 2'b10;
  localparam logic [3:0]       c_DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

  logic [2:0]       w_raw;
  logic [1:0]       w_light  [3];
  logic [2:0]       w_sensor;
  logic [CNT_W-1:0] w_count  [3];

  assign w_raw      = {ns_raw, ew_left_raw, ew_str_raw};
  assign w_light[0] = ew_str_light;
  assign w_light[1] = ew_left_light;
  assign w_light[2] = ns_light;

`ifdef STARVATION_FLAG_EN
  logic [2:0] w_starve;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_lane
    logic             r_s1;
    logic             r_s2;
    logic             r_deb;
    logic             r_deb_d;
    logic [3:0]       r_dcnt;
    logic [1:0]       r_prev;
    logic [CNT_W-1:0] r_count;
    logic             w_arrival;
    logic             w_served;

    assign w_arrival = r_deb & ~r_deb_d;
    // Green phase just ended: everything queued so far has been served.
    assign w_served  = (r_prev == c_GREEN) && (w_light[g] != c_GREEN);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_deb   <= 1'b0;
        r_deb_d <= 1'b0;
        r_dcnt  <= '0;
        r_prev  <= c_RED;
        r_count <= '0;
      end else begin
        r_s1    <= w_raw[g];
        r_s2    <= r_s1;
        r_deb_d <= r_deb;
        r_prev  <= w_light[g];

        if (r_s2 == r_deb) begin
          r_dcnt <= '0;
        end else if (r_dcnt == c_DEB_LAST) begin
          r_deb  <= r_s2;
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + 4'd1;
        end

        if (w_served) begin
          r_count <= CNT_W'(w_arrival);
        end else if (w_arrival && (r_count != c_CNT_MAX)) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end

    assign w_sensor[g] = r_deb | (r_count != '0);
    assign w_count[g]  = r_count;

`ifdef STARVATION_FLAG_EN
    localparam int                 c_TIMER_W = $clog2(STARVE_CYCLES) + 1;
    localparam logic [c_TIMER_W-1:0] c_STARVE  = c_TIMER_W'(STARVE_CYCLES);
    logic [c_TIMER_W-1:0] r_wait;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wait <= '0;
      end else if ((w_light[g] == c_GREEN) || !w_sensor[g]) begin
        r_wait <= '0;
      end else if (r_wait != c_STARVE) begin
        r_wait <= r_wait + c_TIMER_W'(1);
      end
    end

    assign w_starve[g] = (r_wait == c_STARVE);
`endif
  end

  assign ew_str_sensor  = w_sensor[0];
  assign ew_left_sensor = w_sensor[1];
  assign ns_sensor      = w_sensor[2];
  assign ew_str_count   = w_count[0];
  assign ew_left_count  = w_count[1];
  assign ns_count       = w_count[2];

`ifdef STARVATION_FLAG_EN
  assign ew_str_starve  = w_starve[0];
  assign ew_left_starve = w_starve[1];
  assign ns_starve      = w_starve[2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
`default_nettype none
// Testbench for traffic_sensor_conditioner: directed vector table, hand-written
// corner sequences and a randomized run checked against a reference model.
module tb_traffic_sensor_conditioner;

  localparam int         DEB  = 2;
  localparam int         CMAX = 15;
  localparam logic [1:0] RED  = 2'b00;
  localparam logic [1:0] YEL  = 2'b01;
  localparam logic [1:0] GRN  = 2'b10;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] raw   = 3'b000;
  logic [1:0] light [3];
  wire        s0, s1, s2;
  wire  [3:0] c0, c1, c2;
`ifdef STARVATION_FLAG_EN
  wire        st0, st1, st2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  traffic_sensor_conditioner dut (
    .clk           (clk),
    .reset         (reset),
    .ew_str_raw    (raw[0]),
    .ew_left_raw   (raw[1]),
    .ns_raw        (raw[2]),
    .ew_str_light  (light[0]),
    .ew_left_light (light[1]),
    .ns_light      (light[2]),
    .ew_str_sensor (s0),
    .ew_left_sensor(s1),
    .ns_sensor     (s2),
`ifdef STARVATION_FLAG_EN
    .ew_str_starve (st0),
    .ew_left_starve(st1),
    .ns_starve     (st2),
`endif
    .ew_str_count  (c0),
    .ew_left_count (c1),
    .ns_count      (c2)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic get_sens(int l);
    case (l)
      0:       return s0;
      1:       return s1;
      default: return s2;
    endcase
  endfunction

  function automatic logic [3:0] get_cnt(int l);
    case (l)
      0:       return c0;
      1:       return c1;
      default: return c2;
    endcase
  endfunction

  // Reference model: the debounced value flips once the last DEB synchronized
  // samples (raw seen two edges earlier) all disagree with it.
  bit         hist   [3][$];
  bit         m_deb  [3];
  bit         m_debd [3];
  logic [1:0] m_prev [3];
  int         m_cnt  [3];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < 3; l++) begin
        hist[l].delete();
        for (int k = 0; k < DEB + 2; k++) hist[l].push_back(1'b0);
        m_deb[l]  = 1'b0;
        m_debd[l] = 1'b0;
        m_prev[l] = RED;
        m_cnt[l]  = 0;
      end
    end else begin
      for (int l = 0; l < 3; l++) begin
        bit arr, srv, flip;
        arr = m_deb[l] && !m_debd[l];
        srv = (m_prev[l] == GRN) && (light[l] != GRN);
        if (srv)                          m_cnt[l] = arr ? 1 : 0;
        else if (arr && m_cnt[l] < CMAX) m_cnt[l] = m_cnt[l] + 1;
        m_debd[l] = m_deb[l];
        m_prev[l] = light[l];
        hist[l].push_front(raw[l]);
        void'(hist[l].pop_back());
        flip = 1'b1;
        for (int k = 2; k < DEB + 2; k++) if (hist[l][k] == m_deb[l]) flip = 1'b0;
        if (flip) m_deb[l] = !m_deb[l];
      end
    end
  end

  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      check($sformatf("model_sensor%0d", l), 32'(get_sens(l)),
            32'(m_deb[l] || (m_cnt[l] != 0)));
      check($sformatf("model_count%0d", l), 32'(get_cnt(l)), 32'(m_cnt[l]));
    end
  end

  typedef struct {
    string      nm;
    logic [2:0] raw;
    logic [1:0] l_str, l_left, l_ns;
    int         hold;
    logic [2:0] e_sens;
    int         e_str, e_left, e_ns;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string nm, logic [2:0] r, logic [1:0] ls, logic [1:0] ll,
                              logic [1:0] ln, int h, logic [2:0] es, int cs, int cl, int cn);
    vec_t v;
    v.nm = nm; v.raw = r; v.l_str = ls; v.l_left = ll; v.l_ns = ln; v.hold = h;
    v.e_sens = es; v.e_str = cs; v.e_left = cl; v.e_ns = cn;
    tbl.push_back(v);
  endfunction

  task automatic clear_all();
    raw = 3'b000;
    repeat (8) @(negedge clk);
    for (int l = 0; l < 3; l++) light[l] = GRN;
    @(negedge clk);
    for (int l = 0; l < 3; l++) light[l] = YEL;
    @(negedge clk);
    for (int l = 0; l < 3; l++) light[l] = RED;
    @(negedge clk);
  endtask

  initial begin
    for (int l = 0; l < 3; l++) light[l] = RED;
    raw = 3'b111;

    // Reset held with all loops occupied
    @(negedge clk);
    check("rst_sens", 32'({s2, s1, s0}), 32'd0);
    check("rst_cnt", 32'({c2, c1, c0}), 32'd0);
    @(negedge clk);
    check("rst_sens2", 32'({s2, s1, s0}), 32'd0);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_edge3", 32'(s0), 32'd0);
    @(negedge clk);
    check("rst_edge4", 32'(s0), 32'd1);
    clear_all();

    // Directed vectors, raw = {ns, left, str}
    add("glitch_hi", 3'b100, RED, RED, RED, 1, 3'b000, 0, 0, 0);
    add("glitch_lo", 3'b000, RED, RED, RED, 8, 3'b000, 0, 0, 0);
    for (int p = 1; p <= 3; p++) begin
      add($sformatf("queue_hi%0d", p), 3'b010, RED, RED, RED, 5, 3'b010, 0, p, 0);
      add($sformatf("queue_lo%0d", p), 3'b000, RED, RED, RED, 6, 3'b010, 0, p, 0);
    end
    add("queue_grn", 3'b000, RED, GRN, RED, 1, 3'b010, 0, 3, 0);
    add("queue_srv", 3'b000, RED, YEL, RED, 1, 3'b000, 0, 0, 0);
    add("queue_red", 3'b000, RED, RED, RED, 1, 3'b000, 0, 0, 0);
    add("simul_grn", 3'b001, GRN, RED, RED, 4, 3'b001, 0, 0, 0);
    add("simul_srv", 3'b001, YEL, RED, RED, 1, 3'b001, 1, 0, 0);
    add("simul_lo",  3'b000, RED, RED, RED, 8, 3'b001, 1, 0, 0);
    add("simul_grn2", 3'b000, GRN, RED, RED, 1, 3'b001, 1, 0, 0);
    add("simul_clr", 3'b000, YEL, RED, RED, 1, 3'b000, 0, 0, 0);
    add("simul_red", 3'b000, RED, RED, RED, 1, 3'b000, 0, 0, 0);

    foreach (tbl[i]) begin
      raw      = tbl[i].raw;
      light[0] = tbl[i].l_str;
      light[1] = tbl[i].l_left;
      light[2] = tbl[i].l_ns;
      repeat (tbl[i].hold) @(negedge clk);
      check({tbl[i].nm, "_sens"}, 32'({s2, s1, s0}), 32'(tbl[i].e_sens));
      check({tbl[i].nm, "_str"},  32'(c0), 32'(tbl[i].e_str));
      check({tbl[i].nm, "_left"}, 32'(c1), 32'(tbl[i].e_left));
      check({tbl[i].nm, "_ns"},   32'(c2), 32'(tbl[i].e_ns));
    end

    // Saturation on the n-s lane
    for (int i = 0; i < 20; i++) begin
      raw = 3'b100;
      repeat (5) @(negedge clk);
      check($sformatf("sat_cnt%0d", i), 32'(c2), 32'((i + 1 > CMAX) ? CMAX : i + 1));
      raw = 3'b000;
      repeat (6) @(negedge clk);
    end
    check("sat_final", 32'(c2), 32'(CMAX));
    check("sat_sens", 32'(s2), 32'd1);
    light[2] = GRN;
    @(negedge clk);
    light[2] = YEL;
    @(negedge clk);
    check("sat_clr", 32'(c2), 32'd0);
    light[2] = RED;
    @(negedge clk);

`ifdef STARVATION_FLAG_EN
    raw = 3'b100;
    repeat (67) @(negedge clk);
    check("starve_early", 32'(st2), 32'd0);
    @(negedge clk);
    check("starve_set", 32'(st2), 32'd1);
    repeat (2) @(negedge clk);
    check("starve_hold", 32'(st2), 32'd1);
    check("starve_other", 32'({st1, st0}), 32'd0);
    light[2] = GRN;
    @(negedge clk);
    check("starve_clr", 32'(st2), 32'd0);
    clear_all();
`endif

    // Randomized traffic with a mid-run asynchronous reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        if ($urandom_range(3) == 0)  raw[l] = ~raw[l];
        if ($urandom_range(15) == 0) light[l] = 2'($urandom_range(3));
      end
      if (cyc == 1500) begin
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
